// File: rtl/seq_sched_pkg.sv
// Shared types and sizing helpers for the sequence-detector scheduler.
package seq_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLR   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_WORD_W = 8;

    // Wide enough to hold WORD_W itself, so a word that matches on every bit still fits.
    function automatic int cnt_width(input int word_w);
        return $clog2(word_w) + 1;
    endfunction

    function automatic int id_width(input int n_req);
        return (n_req < 2) ? 1 : $clog2(n_req);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at i_rr_ptr and wraps
// upward, and the first set request wins.
module rr_arbiter
    import seq_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = id_width(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_rr_ptr,
    output logic [N_REQ-1:0] o_win,
    output logic [ID_W-1:0]  o_win_id,
    output logic             o_any
);

    always_comb begin
        o_win    = '0;
        o_win_id = '0;
        o_any    = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!o_any && i_req[(int'(i_rr_ptr) + k) % N_REQ]) begin
                o_any                                  = 1'b1;
                o_win_id                               = ID_W'((int'(i_rr_ptr) + k) % N_REQ);
                o_win[(int'(i_rr_ptr) + k) % N_REQ]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Time-shares one serial sequence detector among N_REQ requesters: it grants
// round-robin, clears the detector, shifts the word MSB-first and counts matches.
module seq_detect_scheduler
    import seq_sched_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int WORD_W = DEF_WORD_W,
    parameter int CNT_W  = cnt_width(WORD_W),
    parameter int ID_W   = id_width(N_REQ)
) (
    input  logic                      clk_o,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*WORD_W-1:0]   word_i,
    output logic [N_REQ-1:0]          gnt,
    output logic                      det_clr,
    output logic                      det_x,
    input  logic                      det_z,
    output logic                      busy,
    output logic                      done,
    output logic [ID_W-1:0]           done_id,
    output logic [CNT_W-1:0]          match_cnt
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

    sched_state_t      r_state;
    sched_state_t      w_next;

    logic [N_REQ-1:0]  w_win;
    logic [ID_W-1:0]   w_win_id;
    logic              w_any;
    logic [N_REQ-1:0]  w_gnt;
    logic              w_det_x;
    logic [WORD_W-1:0] w_word;

    logic [ID_W-1:0]   r_rr_ptr;
    logic [WORD_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_bit_idx;
    logic [ID_W-1:0]   r_id;
    logic              r_det_clr;
    logic              r_busy;
    logic              r_done;
    logic [ID_W-1:0]   r_done_id;
    logic [CNT_W-1:0]  r_match_cnt;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .i_req    (req),
        .i_rr_ptr (r_rr_ptr),
        .o_win    (w_win),
        .o_win_id (w_win_id),
        .o_any    (w_any)
    );

    assign w_word = word_i[int'(w_win_id) * WORD_W +: WORD_W];

    always_comb begin
        w_next  = r_state;
        w_gnt   = '0;
        w_det_x = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_gnt  = w_win;
                    w_next = CLR;
                end
            end
            CLR: begin
                w_next = SHIFT;
            end
            SHIFT: begin
                w_det_x = r_shift[WORD_W-1];
                if (r_bit_idx == LAST_BIT) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_o or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Status flags are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk_o or negedge reset) begin
        if (!reset) begin
            r_rr_ptr    <= '0;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_id        <= '0;
            r_det_clr   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_done_id   <= '0;
            r_match_cnt <= '0;
        end else begin
            r_det_clr <= (w_next == CLR);
            r_busy    <= (w_next != IDLE);
            r_done    <= (w_next == DONE);
            if (w_next == DONE) begin
                r_done_id <= r_id;
            end
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_shift <= w_word;
                        r_id    <= w_win_id;
                    end
                end
                CLR: begin
                    r_match_cnt <= '0;
                    r_bit_idx   <= '0;
                end
                SHIFT: begin
                    if (det_z && (r_match_cnt != '1)) begin
                        r_match_cnt <= r_match_cnt + 1'b1;
                    end
                    r_shift   <= r_shift << 1;
                    r_bit_idx <= r_bit_idx + 1'b1;
                end
                DONE: begin
                    r_rr_ptr <= (r_id == LAST_ID) ? '0 : r_id + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // The grant is combinational, so it is gated to keep it low while reset is held.
    assign gnt       = reset ? w_gnt : '0;
    assign det_x     = w_det_x;
    assign det_clr   = r_det_clr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign done_id   = r_done_id;
    assign match_cnt = r_match_cnt;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Bench for seq_detect_scheduler: it predicts the outputs with a job-level model and
// drives det_z from a "1101" overlapping detector that det_clr clears.
module tb_seq_detect_scheduler;

    localparam int N_REQ  = 4;
    localparam int WORD_W = 8;
    localparam int CNT_W  = 4;
    localparam int ID_W   = 2;
    localparam int LAT    = WORD_W + 2;

    logic                    clk_o  = 1'b0;
    logic                    reset  = 1'b0;
    logic [N_REQ-1:0]        req    = '0;
    logic [N_REQ*WORD_W-1:0] word_i = '0;
    logic [N_REQ-1:0]        gnt;
    logic                    det_clr, det_x, det_z, busy, done;
    logic [ID_W-1:0]         done_id;
    logic [CNT_W-1:0]        match_cnt;

    always #5 clk_o = ~clk_o;

    seq_detect_scheduler #(
        .N_REQ(N_REQ), .WORD_W(WORD_W), .CNT_W(CNT_W), .ID_W(ID_W)
    ) dut (
        .clk_o(clk_o), .reset(reset), .req(req), .word_i(word_i), .gnt(gnt),
        .det_clr(det_clr), .det_x(det_x), .det_z(det_z), .busy(busy),
        .done(done), .done_id(done_id), .match_cnt(match_cnt)
    );

    // The detector advances only while serial bits are being presented.
    logic [2:0] hist = 3'b000;
    assign det_z = ({hist, det_x} == 4'b1101);
    always @(posedge clk_o) begin
        if (det_clr) hist <= 3'b000;
        else if (busy && !done) hist <= {hist[1:0], det_x};
    end

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    bit                m_active = 1'b0;
    int                m_t0 = 0, m_id = 0, m_ptr = 0, m_did = 0, m_cnt = 0;
    logic [WORD_W-1:0] m_word = '0;
    logic [N_REQ-1:0]  last_gnt = '0;

    int               g_cyc[$];
    logic [N_REQ-1:0] g_val[$];
    int               d_cyc[$];
    int               d_id[$];
    int               d_cnt[$];
    bit               xq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int rr_win(input logic [N_REQ-1:0] r, input int ptr);
        for (int k = 0; k < N_REQ; k++)
            if (r[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        return -1;
    endfunction

    // Number of "1101" matches (overlapping) among the first n bits, sent MSB first.
    function automatic int cnt_prefix(input logic [WORD_W-1:0] w, input int n);
        int       c = 0;
        bit [3:0] h = 4'b0000;
        for (int k = 0; k < n; k++) begin
            h = {h[2:0], w[WORD_W-1-k]};
            if (k >= 3 && h == 4'b1101) c++;
        end
        return (c > 15) ? 15 : c;
    endfunction

    task automatic check_cycle();
        logic [N_REQ-1:0] e_gnt = '0;
        bit e_clr = 0, e_x = 0, e_busy = 0, e_done = 0;
        int p, w;
        if (!reset) begin
            m_active = 0; m_ptr = 0; m_did = 0; m_cnt = 0;
        end else if (!m_active) begin
            w = rr_win(req, m_ptr);
            if (w >= 0) begin
                e_gnt[w] = 1'b1;
                m_active = 1; m_t0 = cyc; m_id = w;
                m_word   = word_i[w*WORD_W +: WORD_W];
            end
        end else begin
            p = cyc - m_t0;
            e_busy = 1;
            if (p == 1) e_clr = 1;
            else if (p <= WORD_W + 1) begin
                e_x   = m_word[WORD_W-1-(p-2)];
                m_cnt = cnt_prefix(m_word, p - 2);
            end else begin
                e_done = 1;
                m_cnt  = cnt_prefix(m_word, WORD_W);
                m_did  = m_id;
            end
        end
        chk("gnt",       32'(gnt),       32'(e_gnt));
        chk("det_clr",   32'(det_clr),   32'(e_clr));
        chk("det_x",     32'(det_x),     32'(e_x));
        chk("busy",      32'(busy),      32'(e_busy));
        chk("done",      32'(done),      32'(e_done));
        chk("done_id",   32'(done_id),   32'(m_did));
        chk("match_cnt", 32'(match_cnt), 32'(m_cnt));
        if (m_active && (cyc - m_t0 == LAT)) begin
            m_active = 0;
            m_ptr    = (m_id + 1) % N_REQ;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk_o);
            cyc++;
            last_gnt = gnt;
            if (reset && gnt != '0) begin g_cyc.push_back(cyc); g_val.push_back(gnt); end
            if (reset && done) begin
                d_cyc.push_back(cyc); d_id.push_back(int'(done_id)); d_cnt.push_back(int'(match_cnt));
            end
            if (det_clr) xq.delete();
            else if (busy && !done) xq.push_back(det_x);
            check_cycle();
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk_o); #1; end
    endtask

    task automatic set_word(input int i, input logic [WORD_W-1:0] w);
        word_i[i*WORD_W +: WORD_W] = w;
    endtask

    task automatic do_reset();
        reset = 1'b0; tick(3); reset = 1'b1;
    endtask

    task automatic job(input int i, input logic [WORD_W-1:0] w);
        set_word(i, w);
        req = '0; req[i] = 1'b1;
        tick(1);
        req[i] = 1'b0;
        tick(LAT + 1);
    endtask

    task automatic pin_job(input string nm, input logic [N_REQ-1:0] eg, input int eid, input int ecnt);
        if (g_val.size() == 0 || d_cyc.size() == 0) chk({nm, "_seen"}, 32'd0, 32'd1);
        else begin
            chk({nm, "_gnt"}, 32'(g_val[$]), 32'(eg));
            chk({nm, "_id"},  32'(d_id[$]),  32'(eid));
            chk({nm, "_cnt"}, 32'(d_cnt[$]), 32'(ecnt));
            chk({nm, "_lat"}, 32'(d_cyc[$] - g_cyc[$]), 32'(LAT));
        end
    endtask

    initial begin
        int               base, nd;
        logic [WORD_W-1:0] v;

        do_reset();

        job(0, 8'hDA);
        pin_job("single", 4'b0001, 0, 2);
        v = '0;
        foreach (xq[k]) v = {v[WORD_W-2:0], xq[k]};
        chk("single_nbits", 32'(xq.size()), 32'd8);
        chk("single_bits",  32'(v), 32'hDA);

        job(1, 8'h00);
        pin_job("zero", 4'b0010, 1, 0);
        job(2, 8'hDD);
        pin_job("dd", 4'b0100, 2, 2);

        do_reset();
        base = g_val.size();
        req = '1;
        tick(4 * (LAT + 1) + 2);
        req = '0;
        tick(LAT + 2);
        if (g_val.size() - base < 5) chk("rr_count", 32'(g_val.size() - base), 32'd5);
        else begin
            chk("rr_g0", 32'(g_val[base]),   32'b0001);
            chk("rr_g1", 32'(g_val[base+1]), 32'b0010);
            chk("rr_g2", 32'(g_val[base+2]), 32'b0100);
            chk("rr_g3", 32'(g_val[base+3]), 32'b1000);
            chk("rr_g4", 32'(g_val[base+4]), 32'b0001);
            for (int k = 0; k < 4; k++)
                chk("rr_gap", 32'(g_cyc[base+k+1] - g_cyc[base+k]), 32'(LAT + 1));
        end

        do_reset();
        job(1, 8'h3C);
        base = g_val.size();
        req = 4'b0011;
        tick(LAT + 2);
        req = '0;
        tick(LAT + 1);
        if (g_val.size() - base < 2) chk("fair_count", 32'(g_val.size() - base), 32'd2);
        else begin
            chk("fair_g0", 32'(g_val[base]),   32'b0001);
            chk("fair_g1", 32'(g_val[base+1]), 32'b0010);
        end

        job(2, 8'h06);
        pin_job("clrA", 4'b0100, 2, 0);
        job(3, 8'hA0);
        pin_job("clrB", 4'b1000, 3, 0);

        set_word(0, 8'hDA);
        req = 4'b0001;
        tick(1);
        req = '0;
        tick(5);
        chk("abort_busy", 32'(busy), 32'd1);
        nd = d_cyc.size();
        reset = 1'b0;
        #1;
        chk("abort_gnt",  32'(gnt),       32'd0);
        chk("abort_clr",  32'(det_clr),   32'd0);
        chk("abort_x",    32'(det_x),     32'd0);
        chk("abort_bsy",  32'(busy),      32'd0);
        chk("abort_done", 32'(done),      32'd0);
        chk("abort_id",   32'(done_id),   32'd0);
        chk("abort_cnt",  32'(match_cnt), 32'd0);
        set_word(2, 8'hDD);
        req = 4'b0100;
        tick(2);
        reset = 1'b1;
        tick(1);
        req = '0;
        tick(LAT + 1);
        chk("abort_ndone", 32'(d_cyc.size() - nd), 32'd1);
        pin_job("after_rst", 4'b0100, 2, 2);

        for (int it = 0; it < 2000; it++) begin
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b0; tick(2); reset = 1'b1;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (last_gnt[i]) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 0) set_word(i, WORD_W'($urandom));
                    else set_word(i, {4'b1101, 4'($urandom)});
                    req[i] = 1'b1;
                end
            end
            tick(1);
        end

        req = '1;
        for (int it = 0; it < 300; it++) begin
            for (int i = 0; i < N_REQ; i++)
                if (last_gnt[i]) set_word(i, WORD_W'($urandom));
            tick(1);
        end
        req = '0;
        tick(LAT + 3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/seq_detect_scheduler.md
# seq_detect_scheduler

Time-shares one serial sequence-detector FSM among `N_REQ` requesters. Each requester presents a parallel word. The scheduler grants requesters round-robin, clears the detector, and shifts the granted word into it MSB-first, one bit per `clk_o` cycle. It counts the detector's match pulses and returns the count tagged with the requester id. The block sits between the switch/host capture logic and the detector, and drives the detector's `x` and state-clear inputs.

## Interface
- `N_REQ`, default 4: number of requesters, minimum 2.
- `WORD_W`, default 8: bits per job word.
- `CNT_W`, default $clog2(`WORD_W`)+1: match counter width.
- `ID_W`, default $clog2(`N_REQ`): requester id width.

Ports:
- `clk_o`  in  1  clock. Same debounced clock as the detector.
- `reset`  in  1  reset, asynchronous, active-low.
- `req`  in  `N_REQ`  request[i] level. Held by requester i until it sees `gnt`[i].
- `word_i`  in  `N_REQ`*`WORD_W`  packed words. Word i occupies [i*`WORD_W` +: `WORD_W`].
- `gnt`  out  `N_REQ`  one-hot, one-cycle pulse. The word is captured on this cycle's edge.
- `det_clr`  out  1  synchronous clear pulse to the detector state register.
- `det_x`  out  1  serial bit to the detector.
- `det_z`  in  1  detector Mealy output, valid in the same cycle as `det_x`.
- `busy`  out  1  high from the cycle after the grant until `done` inclusive.
- `done`  out  1  one-cycle completion pulse.
- `done_id`  out  `ID_W`  requester id of the completed job. Valid with `done`, held afterwards.
- `match_cnt`  out  `CNT_W`  number of `det_z` pulses in the job. Valid with `done`, held until the next `CLR`.

## Operation
- FSM states: `IDLE`, `CLR`, `SHIFT`, `DONE`.
- `IDLE`:
  - If any `req` bit is set, arbitrate. Search starts at `rr_ptr` and wraps upward; the first set bit wins.
  - Assert `gnt`[win] combinationally in this cycle.
  - At the edge, load the shift register with `word_i`[win], latch the id, and go to `CLR`.
  - If no `req` bit is set, stay in `IDLE`.
- `CLR`: `det_clr`=1. Clear `match_cnt` and the bit index, then go to `SHIFT`.
- `SHIFT`:
  - `det_x` = shift register MSB.
  - At each edge: if `det_z`=1, increment `match_cnt` (saturates at all-ones); shift left by one; increment the bit index.
  - After the edge that consumes bit `WORD_W`-1, go to `DONE`.
- `DONE`: `done`=1, `done_id` = latched id. Set `rr_ptr` = id+1 mod `N_REQ`, then go to `IDLE`.
- Outside `SHIFT`, `det_x`=0 and `det_z` is ignored.
- `req` deasserting after its grant has no effect on the job.
- A requester still holding `req` at `IDLE` is re-arbitrated normally, with lowest priority because of `rr_ptr`.
- Reset (asynchronous, any state):
  - state=`IDLE`, `rr_ptr`=0, shift register=0.
  - All outputs go to 0: `gnt`, `det_clr`, `det_x`, `busy`, `done`, `done_id`, `match_cnt`.
  - An aborted job produces no `done`.

## Timing
- Grant to first serial bit: 2 cycles (`IDLE`→`CLR`→`SHIFT`).
- `done` is asserted `WORD_W`+2 cycles after the `gnt` cycle.
- Back-to-back jobs: one job per `WORD_W`+3 cycles. The next `gnt` can occur in the cycle after `done`.
- `det_clr` occurs exactly one cycle before the first `SHIFT` cycle. The detector must be in its initial state when bit `WORD_W`-1 of the word is presented.
- Only `gnt` and `det_x` are combinational from state and `req`. All other outputs are registered.

## Structure
- Package `seq_sched_pkg` holds:
  - the state enum `sched_state_t`;
  - default `N_REQ` and `WORD_W` values;
  - a helper function for `CNT_W`/`ID_W`.
- Sub-module `rr_arbiter`:
  - Inputs: `req`, `rr_ptr`.
  - Outputs: one-hot win, win id, any.
  - Purely combinational.
- The top level holds the FSM, shift register, bit counter, match counter and `rr_ptr`.

## Test plan
The bench detector model detects "1101" with overlap and is cleared by `det_clr`.

- Single job: `req`=4'b0001, word0=8'hDA (11011010) → `gnt`=0001 at t0, `det_clr` at t0+1, `det_x` = 1,1,0,1,1,0,1,0 over t0+2..t0+9, `done` at t0+10 with `done_id`=0 and `match_cnt`=2.
- No match: word=8'h00 → `match_cnt`=0. Word=8'hDD → `match_cnt`=2 (first and last nibble).
- Round-robin: `req`=4'b1111 held continuously → grants in order 0001, 0010, 0100, 1000, 0001, each 11 cycles apart.
- Fairness: `rr_ptr`=2 (after granting id 1) with `req`=4'b0011 → next grant is 0001. Then with `req`=4'b0011 again → grant 0010.
- Clear between jobs: job A word ending in "110", followed by job B word starting "1" → no cross-job match; B's `match_cnt` counts B's bits only.
- Reset mid-`SHIFT` (bit 4) → all outputs 0 immediately, no `done`. After release with `req`=4'b0100 → grant 0100 (search starts from 0).
